// File: rtl/ram_bist.sv
// March-style RAM self test: write/read ascending, inverted descending, then
// per-byte write/read pairs, with first-failure capture and registered outputs.
module ram_bist #(
    parameter int ADDR_MSB = 6
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [15:0]         pattern,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_MSB:0]   fail_addr,
    output logic [15:0]         fail_data,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [15:0]         ram_din,
    output logic [1:0]          ram_wen,
    input  logic [15:0]         ram_dout
);

    localparam logic [ADDR_MSB:0] ADDR_FIRST = {(ADDR_MSB+1){1'b0}};
    localparam logic [ADDR_MSB:0] ADDR_LAST  = {(ADDR_MSB+1){1'b1}};
    localparam logic [ADDR_MSB:0] ADDR_ONE   = (ADDR_MSB+1)'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_WRI  = 3'd3,
        S_RDI  = 3'd4,
        S_BW   = 3'd5,
        S_BR   = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    // state_r names the access currently on the RAM port; addr_r is its address
    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_MSB:0] addr_r;
    logic [ADDR_MSB:0] addr_nxt_s;
    logic [15:0]       p_r;
    logic [15:0]       p_nxt_s;
    logic [15:0]       e_nxt_s;
    logic              accept_s;
    logic              mismatch_s;

    logic              cmp_vld_r;
    logic [ADDR_MSB:0] cmp_addr_r;
    logic [15:0]       cmp_exp_r;
    logic              cmp_vld_d_s;
    logic [15:0]       cmp_exp_d_s;

    logic              cen_d_s;
    logic [1:0]        wen_d_s;
    logic [15:0]       din_d_s;
    logic              busy_d_s;
    logic              done_d_s;
    logic              pass_d_s;
    logic [ADDR_MSB:0] fail_addr_d_s;
    logic [15:0]       fail_data_d_s;

    function automatic logic [15:0] base_word(input logic [15:0] p, input logic [ADDR_MSB:0] a);
        return p ^ 16'(a);
    endfunction

    function automatic logic [15:0] read_expect(input state_t st, input logic [15:0] p,
                                                input logic [ADDR_MSB:0] a);
        logic [15:0] ne;
        ne = ~base_word(p, a);
        case (st)
            S_RD:    return base_word(p, a);
            S_RDI:   return ne;
            S_BR:    return a[0] ? {ne[15:8], 8'hA5} : {8'h5A, ne[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    assign accept_s   = (state_r == S_IDLE) && start;
    assign mismatch_s = cmp_vld_r && (ram_dout != cmp_exp_r);
    assign ram_addr   = addr_r;

    // State and address registers
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            addr_r  <= ADDR_FIRST;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    // Next access: phase sequencing with explicit terminal-address compares
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        if (mismatch_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_nxt_s = S_WR;
                        addr_nxt_s  = ADDR_FIRST;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_WR: begin
                    if (addr_r == ADDR_LAST) begin
                        state_nxt_s = S_RD;
                        addr_nxt_s  = ADDR_FIRST;
                    end else begin
                        addr_nxt_s  = addr_r + ADDR_ONE;
                    end
                end
                S_RD: begin
                    if (addr_r == ADDR_LAST) begin
                        state_nxt_s = S_WRI;
                        addr_nxt_s  = ADDR_LAST;
                    end else begin
                        addr_nxt_s  = addr_r + ADDR_ONE;
                    end
                end
                S_WRI: begin
                    if (addr_r == ADDR_FIRST) begin
                        state_nxt_s = S_RDI;
                        addr_nxt_s  = ADDR_LAST;
                    end else begin
                        addr_nxt_s  = addr_r - ADDR_ONE;
                    end
                end
                S_RDI: begin
                    if (addr_r == ADDR_FIRST) begin
                        state_nxt_s = S_BW;
                        addr_nxt_s  = ADDR_FIRST;
                    end else begin
                        addr_nxt_s  = addr_r - ADDR_ONE;
                    end
                end
                S_BW: begin
                    state_nxt_s = S_BR;
                end
                S_BR: begin
                    if (addr_r == ADDR_LAST) begin
                        state_nxt_s = S_FIN;
                    end else begin
                        state_nxt_s = S_BW;
                        addr_nxt_s  = addr_r + ADDR_ONE;
                    end
                end
                S_FIN: begin
                    state_nxt_s = S_IDLE;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Register inputs: RAM port for the next access, status and compare stage
    always_comb begin
        if (accept_s) begin
            p_nxt_s = pattern;
        end else begin
            p_nxt_s = p_r;
        end
        e_nxt_s = base_word(p_nxt_s, addr_nxt_s);

        cen_d_s = 1'b1;
        wen_d_s = 2'b11;
        din_d_s = 16'h0000;
        case (state_nxt_s)
            S_WR: begin
                cen_d_s = 1'b0;
                wen_d_s = 2'b00;
                din_d_s = e_nxt_s;
            end
            S_WRI: begin
                cen_d_s = 1'b0;
                wen_d_s = 2'b00;
                din_d_s = ~e_nxt_s;
            end
            S_RD, S_RDI, S_BR: begin
                cen_d_s = 1'b0;
            end
            S_BW: begin
                cen_d_s = 1'b0;
                if (addr_nxt_s[0]) begin
                    wen_d_s = 2'b10;
                    din_d_s = 16'h00A5;
                end else begin
                    wen_d_s = 2'b01;
                    din_d_s = 16'h5A00;
                end
            end
            default: begin
                cen_d_s = 1'b1;
                wen_d_s = 2'b11;
                din_d_s = 16'h0000;
            end
        endcase

        busy_d_s      = busy;
        done_d_s      = done;
        pass_d_s      = pass;
        fail_addr_d_s = fail_addr;
        fail_data_d_s = fail_data;
        if (accept_s) begin
            busy_d_s      = 1'b1;
            done_d_s      = 1'b0;
            pass_d_s      = 1'b0;
            fail_addr_d_s = ADDR_FIRST;
            fail_data_d_s = 16'h0000;
        end else if (mismatch_s) begin
            busy_d_s      = 1'b0;
            done_d_s      = 1'b1;
            pass_d_s      = 1'b0;
            fail_addr_d_s = cmp_addr_r;
            fail_data_d_s = ram_dout;
        end else if (state_r == S_FIN) begin
            busy_d_s      = 1'b0;
            done_d_s      = 1'b1;
            pass_d_s      = 1'b1;
        end else begin
            busy_d_s      = busy;
        end

        cmp_vld_d_s = ((state_r == S_RD) || (state_r == S_RDI) || (state_r == S_BR)) && !mismatch_s;
        cmp_exp_d_s = read_expect(state_r, p_r, addr_r);
    end

    // Output, pattern and compare-stage registers
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= ADDR_FIRST;
            fail_data  <= 16'h0000;
            ram_cen    <= 1'b1;
            ram_wen    <= 2'b11;
            ram_din    <= 16'h0000;
            p_r        <= 16'h0000;
            cmp_vld_r  <= 1'b0;
            cmp_addr_r <= ADDR_FIRST;
            cmp_exp_r  <= 16'h0000;
        end else begin
            busy       <= busy_d_s;
            done       <= done_d_s;
            pass       <= pass_d_s;
            fail_addr  <= fail_addr_d_s;
            fail_data  <= fail_data_d_s;
            ram_cen    <= cen_d_s;
            ram_wen    <= wen_d_s;
            ram_din    <= din_d_s;
            p_r        <= p_nxt_s;
            cmp_vld_r  <= cmp_vld_d_s;
            cmp_addr_r <= addr_r;
            cmp_exp_r  <= cmp_exp_d_s;
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist with an 8-word RAM model (optional fault injection) and a
// schedule-level reference of the march sequence and its expected outcome.
module tb_ram_bist;

    localparam int N = 8;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = 16'h0000;
    logic        busy, done, pass, ram_cen;
    logic [2:0]  fail_addr, ram_addr;
    logic [15:0] fail_data, ram_din;
    logic [1:0]  ram_wen;
    logic [15:0] ram_dout = 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int fault_mode = 0;   // 0 clean, 1 word5 bit3 stuck-at-0, 2 word2 ignores high-byte-only write

    logic [15:0] mem [N];

    typedef struct {
        bit          rd;
        logic [2:0]  a;
        logic [1:0]  wen;
        logic [15:0] din;
        logic [15:0] exp;
    } acc_t;
    acc_t sched[$];

    ram_bist #(.ADDR_MSB(2)) dut (
        .mclk(mclk), .reset_n(reset_n), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_din(ram_din), .ram_wen(ram_wen),
        .ram_dout(ram_dout)
    );

    always #5 mclk = ~mclk;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 16'h0000;
    end

    always @(posedge mclk) begin
        if (!ram_cen) begin
            if (!(fault_mode == 2 && ram_wen == 2'b01 && ram_addr == 3'd2)) begin
                if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
                if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            end
            if (fault_mode == 1 && ram_addr == 3'd5 && ram_wen != 2'b11) mem[5][3] <= 1'b0;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic push_acc(input bit rd, input logic [2:0] a, input logic [1:0] wen,
                            input logic [15:0] din, input logic [15:0] exp);
        acc_t t;
        t.rd = rd; t.a = a; t.wen = wen; t.din = din; t.exp = exp;
        sched.push_back(t);
    endtask

    task automatic build_sched(input logic [15:0] p);
        logic [2:0]  a;
        logic [15:0] e;
        sched.delete();
        for (int i = 0; i < N; i++) begin a = 3'(i); e = p ^ 16'(a); push_acc(1'b0, a, 2'b00, e, 16'h0); end
        for (int i = 0; i < N; i++) begin a = 3'(i); e = p ^ 16'(a); push_acc(1'b1, a, 2'b11, 16'h0, e); end
        for (int i = 0; i < N; i++) begin a = 3'(N-1-i); e = p ^ 16'(a); push_acc(1'b0, a, 2'b00, ~e, 16'h0); end
        for (int i = 0; i < N; i++) begin a = 3'(N-1-i); e = p ^ 16'(a); push_acc(1'b1, a, 2'b11, 16'h0, ~e); end
        for (int i = 0; i < N; i++) begin
            a = 3'(i); e = ~(p ^ 16'(a));
            if (i % 2 == 0) begin
                push_acc(1'b0, a, 2'b01, 16'h5A00, 16'h0);
                push_acc(1'b1, a, 2'b11, 16'h0, {8'h5A, e[7:0]});
            end else begin
                push_acc(1'b0, a, 2'b10, 16'h00A5, 16'h0);
                push_acc(1'b1, a, 2'b11, 16'h0, {e[15:8], 8'hA5});
            end
        end
    endtask

    // Runs one march: reference outcome, then cycle-by-cycle port and status checks
    task automatic run_march(input logic [15:0] p, input int fm, input bit hold, input bit already);
        logic [15:0] m [N];
        logic [15:0] w, fdata;
        logic [2:0]  faddr;
        logic [21:0] obs, expv;
        int fidx, d, last;
        bit exp_pass;
        build_sched(p);
        for (int i = 0; i < N; i++) m[i] = 16'h0000;
        fidx = 0; faddr = 3'd0; fdata = 16'h0000;
        for (int i = 0; i < sched.size(); i++) begin
            if (sched[i].rd) begin
                if (m[sched[i].a] != sched[i].exp) begin
                    fidx = i + 1; faddr = sched[i].a; fdata = m[sched[i].a];
                    break;
                end
            end else begin
                w = m[sched[i].a];
                if (!(fm == 2 && sched[i].wen == 2'b01 && sched[i].a == 3'd2)) begin
                    if (!sched[i].wen[1]) w[15:8] = sched[i].din[15:8];
                    if (!sched[i].wen[0]) w[7:0]  = sched[i].din[7:0];
                end
                if (fm == 1 && sched[i].a == 3'd5) w[3] = 1'b0;
                m[sched[i].a] = w;
            end
        end
        exp_pass = (fidx == 0);
        d = exp_pass ? 6*N + 2 : fidx + 2;
        last = hold ? d : d + 2;

        fault_mode = fm;
        if (!already) @(negedge mclk);
        pattern = p;
        start = 1'b1;
        @(posedge mclk);
        for (int k = 1; k <= last; k++) begin
            @(negedge mclk);
            if (k == 1) start = hold;
            if (k < d) begin
                vectors++;
                if ({busy, done, pass} !== 3'b100)
                    $display("FAIL status_run cyc=%0d got bdp=%b want 100", k, {busy, done, pass});
                if (k <= 6*N) begin
                    obs  = {ram_cen, ram_addr, ram_wen, sched[k-1].rd ? 16'h0000 : ram_din};
                    expv = {1'b0, sched[k-1].a, sched[k-1].wen, sched[k-1].rd ? 16'h0000 : sched[k-1].din};
                    vectors++;
                    if (obs !== expv) begin
                        miscompares++;
                        $display("FAIL trace cyc=%0d got cen/addr/wen/din=%h want %h", k, obs, expv);
                    end
                end else begin
                    vectors++;
                    if (ram_cen !== 1'b1) begin
                        miscompares++;
                        $display("FAIL fin_cen cyc=%0d got %b want 1", k, ram_cen);
                    end
                end
                if ({busy, done, pass} !== 3'b100) miscompares++;
            end else if (k == d) begin
                obs  = {busy, done, pass, fail_addr, fail_data};
                expv = {1'b0, 1'b1, exp_pass, faddr, fdata};
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL result cyc=%0d got b/d/p/faddr/fdata=%h want %h", k, obs, expv);
                end
                vectors++;
                if ({ram_cen, ram_wen} !== 3'b111) begin
                    miscompares++;
                    $display("FAIL end_port cyc=%0d got cen/wen=%b want 111", k, {ram_cen, ram_wen});
                end
            end else begin
                vectors++;
                if ({busy, done, ram_cen} !== 3'b011) begin
                    miscompares++;
                    $display("FAIL after_end cyc=%0d got busy/done/cen=%b want 011", k, {busy, done, ram_cen});
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        logic [43:0] obs;
        obs = {busy, done, pass, fail_addr, fail_data, ram_addr, ram_cen, ram_din, ram_wen};
        vectors++;
        if (obs !== {1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 16'h0000, 2'b11}) begin
            miscompares++;
            $display("FAIL %s got outputs=%h want reset values", tag, obs);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge mclk);
        check_reset_vals("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_clean_pass();
        run_march(16'h0000, 0, 1'b0, 1'b0);
        vectors++;
        if ({mem[0], mem[1]} !== {16'h5AFF, 16'hFFA5}) begin
            miscompares++;
            $display("FAIL final_mem got w0=%h w1=%h want 5aff ffa5", mem[0], mem[1]);
        end
    endtask

    task automatic test_trace_pattern();
        run_march(16'hA5C3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stuck_bit();
        run_march(16'hFFFF, 1, 1'b0, 1'b0);
        vectors++;
        if ({fail_addr, fail_data, pass} !== {3'd5, 16'hFFF2, 1'b0}) begin
            miscompares++;
            $display("FAIL stuck_bit got addr=%0d data=%h pass=%b want 5 fff2 0", fail_addr, fail_data, pass);
        end
    endtask

    task automatic test_byte_fault();
        logic [15:0] p, ne;
        p = 16'($urandom);
        ne = ~(p ^ 16'h0002);
        while (ne[15:8] == 8'h5A) begin
            p = 16'($urandom);
            ne = ~(p ^ 16'h0002);
        end
        run_march(p, 2, 1'b0, 1'b0);
        vectors++;
        if ({fail_addr, fail_data[15:8]} !== {3'd2, ne[15:8]}) begin
            miscompares++;
            $display("FAIL byte_fault got addr=%0d hi=%h want 2 %h", fail_addr, fail_data[15:8], ne[15:8]);
        end
    endtask

    task automatic test_reset_mid();
        fault_mode = 0;
        @(negedge mclk);
        pattern = 16'($urandom);
        start = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        start = 1'b0;
        repeat (3*N + 2) @(negedge mclk);
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge mclk);
        check_reset_vals("reset_hold");
        reset_n = 1'b1;
        run_march(16'($urandom), 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_march(16'($urandom), 0, 1'b1, 1'b0);
        run_march(16'($urandom), 0, 1'b0, 1'b1);
        run_march(16'hFFFF, 1, 1'b1, 1'b0);
        run_march(16'($urandom), 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_march(16'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_trace_pattern();
        test_stuck_bit();
        test_byte_fault();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Self-contained RAM test initiator. Drives the low-active cen/wen 16-bit scalable RAM port: 1-cycle registered read latency, wen 2'b00 = word write, 2'b01 = high byte, 2'b10 = low byte, 2'b11 = no write.
- Runs a fixed march sequence over the whole address space, compares read data, and reports pass/fail with first-failure capture.
- Used in benches and as an optional power-up memory check in front of data/program RAM.

Parameters:
ADDR_MSB, 6, MSB of RAM word address; N = 2^(ADDR_MSB+1) words tested.

Ports:
mclk  input  1  clock; RAM clocked by the same clock.
reset_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle start request; ignored while busy.
pattern  input  16  base test pattern, sampled on accepted start.
busy  output  1  test in progress.
done  output  1  test finished; level, held until next accepted start.
pass  output  1  valid when done=1; 1 = no mismatch.
fail_addr  output  ADDR_MSB+1  address of first mismatch.
fail_data  output  16  ram_dout observed at first mismatch.
ram_addr  output  ADDR_MSB+1  RAM address.
ram_cen  output  1  RAM chip enable, low active.
ram_din  output  16  RAM write data.
ram_wen  output  2  RAM write enable, low active, per byte.
ram_dout  input  16  RAM read data, valid the cycle after the read access.

Behaviour:
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, ram_addr=0, ram_cen=1, ram_din=0, ram_wen=2'b11.
- All outputs are registered.
- Reset asserted mid-test aborts immediately to the reset state.
- No RAM access is issued outside busy.
- start accepted when busy=0 (including while done=1):
  - latch pattern as P;
  - clear done/pass/fail_*;
  - set busy=1 at the same edge.
- First access occurs in the cycle after acceptance.
- Define E(a) = P ^ zero-extended a.
- States: IDLE, WR, RD, WRI, RDI, BW, BR, FIN. Phases run back-to-back with no idle cycles.
  - WR: a = 0..N-1 ascending, 1 cycle each. cen=0, wen=00, din=E(a).
  - RD: a = 0..N-1 ascending, 1 cycle each. cen=0, wen=11. Expected E(a).
  - WRI: a = N-1..0 descending. Word write of ~E(a).
  - RDI: a = N-1..0 descending, read. Expected ~E(a).
  - BW/BR: a = 0..N-1 ascending, alternating one byte write (BW) then one read (BR) per address.
    - Even a: wen=01, din={8'h5A,8'h00}. Expected {8'h5A, low byte of ~E(a)}.
    - Odd a: wen=10, din={8'h00,8'hA5}. Expected {high byte of ~E(a), 8'hA5}.
  - FIN: set done=1; pass=1 if no mismatch; busy=0; return to IDLE.
- Compare pipeline: each read's expected value and address are registered. ram_dout is compared during the following cycle and captured at that cycle's end. That cycle may carry the next access.
- Mismatch handling: stop on the first mismatch only.
  - At the compare edge: fail_addr = read address, fail_data = ram_dout, done=1, pass=0, busy=0, ram_cen=1, ram_wen=11.
  - At most one further access (the one in the compare cycle) has been issued.
- Pass timing: last access (final BR) is in cycle 6N after acceptance. Its compare is in cycle 6N+1. done=pass=1 and busy=0 are visible from cycle 6N+2.
- Address arithmetic wraps in ADDR_MSB+1 bits.
- The phase-end counter condition is an explicit terminal compare (N-1 or 0), not an overflow.
- start asserted in the same cycle as a mismatch or pass finish is ignored (busy still 1 that cycle).

Test Plan:
- ADDR_MSB=2 (N=8), clean RAM, pattern=16'h0000, start pulse:
  - 48 accesses; done=pass=1 exactly 50 cycles after the start edge;
  - final memory word 0 = 16'h5AFF, word 1 = 16'hFFA5.
- Same, pattern=16'hA5C3: pass=1; trace ram_addr/ram_wen/ram_din per phase against the schedule.
- RAM model with bit 3 of word 5 stuck at 0, pattern=16'hFFFF:
  - first failure at RD, address 5;
  - fail_addr=5, fail_data=16'hFFF2, pass=0, done=1;
  - ram_cen=1 thereafter.
- RAM ignoring wen=01 at word 2 (high byte never written):
  - fail in BR at address 2;
  - fail_data high byte = ~E(2)[15:8], not 8'h5A.
- reset_n pulsed low mid-RDI: all outputs return to reset values immediately. A new start then yields a full pass with the correct timing.
- start held high through the test: only the first edge is accepted; start on the pass/fail edge is ignored; a start the next cycle restarts and clears done.
